// File: rtl/iob_cache_fe_arb_pkg.sv
// Shared constants and defaults for the cache front-end arbiter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package iob_cache_fe_arb_pkg;

    localparam int ARB_RR          = 0;
    localparam int ARB_FIXED       = 1;

    localparam int DEF_N_PORTS     = 2;
    localparam int DEF_ARB_MODE    = ARB_RR;
    localparam int DEF_RD_FIFO_W   = 2;

endpackage

// File: rtl/iob_cache_fe_arb_idfifo.sv
// Register FIFO holding the port ID of each outstanding read.
// Latency: push visible at the head one cycle later; head read is combinational.
// Backpressure: push ignored when full, pop ignored when empty.
module iob_cache_fe_arb_idfifo #(
    parameter int W  = 1,
    parameter int AW = 2
) (
    input  logic          clk_i,
    input  logic          cke_i,
    input  logic          arst_i,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push_en;
    logic          pop_en;

    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign push_en  = push & ~full;
    assign pop_en   = pop & ~empty;
    assign pop_dat  = mem[rptr];

    // Storage array; contents only matter between push and pop.
    always_ff @(posedge clk_i) begin
        if (cke_i && push_en) begin
            mem[wptr] <= push_dat;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the level unchanged.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (cke_i) begin
            if (push_en) wptr <= wptr + 1'b1;
            if (pop_en)  rptr <= rptr + 1'b1;
            level <= level + (AW+1)'(push_en) - (AW+1)'(pop_en);
        end
    end

endmodule

// File: rtl/iob_cache_fe_arb.sv
// N-port IOb front-end arbiter: one master per cycle to the cache, reads routed back by ID FIFO.
// Latency: zero; request and response paths are purely combinational.
// Backpressure: s_ready passes to the granted master only; reads stall while the ID FIFO is full.
module iob_cache_fe_arb
    import iob_cache_fe_arb_pkg::*;
#(
    parameter int N_PORTS   = DEF_N_PORTS,
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 32,
    parameter int ARB_MODE  = DEF_ARB_MODE,
    parameter int RD_FIFO_W = DEF_RD_FIFO_W,
    parameter int PORT_W    = $clog2(N_PORTS)
) (
    input  logic                          clk_i,
    input  logic                          cke_i,
    input  logic                          arst_i,
    input  logic [N_PORTS-1:0]            m_avalid,
    input  logic [N_PORTS*ADDR_W-1:0]     m_addr,
    input  logic [N_PORTS*DATA_W-1:0]     m_wdata,
    input  logic [N_PORTS*(DATA_W/8)-1:0] m_wstrb,
    output logic [N_PORTS-1:0]            m_ready,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [N_PORTS-1:0]            m_rvalid,
    output logic                          s_avalid,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [DATA_W/8-1:0]           s_wstrb,
    input  logic                          s_ready,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_rvalid,
    output logic                          rsp_err_o
);

    localparam int NBYTES = DATA_W / 8;

    logic [PORT_W-1:0]  rr_ptr;
    logic [N_PORTS-1:0] is_rd;
    logic [N_PORTS-1:0] elig;
    logic               gnt_vld;
    logic [PORT_W-1:0]  gnt;
    logic               accept;
    logic               push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [PORT_W-1:0]  head;
    logic               rsp_hit;
    logic [RD_FIFO_W:0] rd_level_unused;

    // Eligibility and grant selection; reads are held off while the ID FIFO is full.
    always_comb begin
        is_rd   = '0;
        elig    = '0;
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            is_rd[i] = (m_wstrb[i*NBYTES +: NBYTES] == '0);
            elig[i]  = m_avalid[i] & (~is_rd[i] | ~fifo_full);
        end
        if (ARB_MODE == ARB_FIXED) begin
            for (int i = N_PORTS - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    gnt_vld = 1'b1;
                    gnt     = PORT_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < N_PORTS; k++) begin
                int idx;
                idx = (int'(rr_ptr) + k) % N_PORTS;
                if (!gnt_vld && elig[idx]) begin
                    gnt_vld = 1'b1;
                    gnt     = PORT_W'(idx);
                end
            end
        end
    end

    // Forward the granted request and steer s_ready back to its master.
    always_comb begin
        s_avalid = gnt_vld;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m_ready  = '0;
        if (gnt_vld) begin
            s_addr  = m_addr[gnt*ADDR_W +: ADDR_W];
            s_wdata = m_wdata[gnt*DATA_W +: DATA_W];
            s_wstrb = m_wstrb[gnt*NBYTES +: NBYTES];
        end
        for (int i = 0; i < N_PORTS; i++) begin
            m_ready[i] = gnt_vld && (gnt == PORT_W'(i)) && s_ready;
        end
    end

    assign accept  = s_avalid & s_ready;
    assign push    = accept & is_rd[gnt];
    assign rsp_hit = s_rvalid & ~fifo_empty;

    // Route the response to the master at the FIFO head; orphan responses are dropped.
    always_comb begin
        m_rvalid = '0;
        m_rdata  = rsp_hit ? s_rdata : '0;
        for (int i = 0; i < N_PORTS; i++) begin
            m_rvalid[i] = rsp_hit && (head == PORT_W'(i));
        end
    end

    // Round-robin pointer moves past the winner only when the cache takes the request.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rr_ptr <= '0;
        end else if (cke_i && accept && ARB_MODE == ARB_RR) begin
            rr_ptr <= (gnt == PORT_W'(N_PORTS - 1)) ? '0 : gnt + 1'b1;
        end
    end

    // Sticky flag for a response with no matching outstanding read.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rsp_err_o <= 1'b0;
        end else if (cke_i && s_rvalid && fifo_empty) begin
            rsp_err_o <= 1'b1;
        end
    end

    iob_cache_fe_arb_idfifo #(
        .W  (PORT_W),
        .AW (RD_FIFO_W)
    ) u_idfifo (
        .clk_i    (clk_i),
        .cke_i    (cke_i),
        .arst_i   (arst_i),
        .push     (push),
        .push_dat (gnt),
        .pop      (s_rvalid),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (rd_level_unused)
    );

endmodule
